os_cmd_collector: RTL and testbench
===================================

// Module: os_cmd_collector
// PURPOSE
//  Front-end stage of the online-shopping platform. Collects the serial,
//  valid-qualified fields that arrive on the shared 16-bit D bus (user id,
//  action, item, number, seller id, amount) and assembles one complete
//  command. It hands that command to the downstream OS action FSM
//  (Buy/Check/Deposit/Return) through a valid/ready handshake.
// PARAMETERS
//  CHK_WAIT  6  cycles after a Check act_valid during which a seller id_valid makes it a stock check
// PORTS
//  clk          in   1   system clock, rising edge
//  rst          in   1   asynchronous reset, active-high
//  id_valid     in   1   D[7:0] carries a user id (in IDLE) or a seller id (in SELLER/CHK_WAIT)
//  act_valid    in   1   D[3:0] carries the Action code
//  item_valid   in   1   D[1:0] carries the Item_id
//  num_valid    in   1   D[5:0] carries the Item_num
//  amnt_valid   in   1   D[15:0] carries the Money amount
//  D            in   16  shared data bus (DATA union)
//  cmd_ready    in   1   downstream accepts the command this cycle
//  cmd_valid    out  1   command held stable until accepted
//  cmd_act      out  4   Action: 1 Buy, 2 Check, 4 Deposit, 8 Return
//  cmd_user     out  8   current user id
//  cmd_new_user out  1   a user id was received since the previous command
//  cmd_seller   out  8   seller id (Buy/Return/stock check), else 0
//  cmd_item     out  2   Item_id (Buy/Return), else 0
//  cmd_num      out  6   Item_num (Buy/Return), else 0
//  cmd_amnt     out  16  deposit amount (Deposit), else 0
//  cmd_chk_stk  out  1   Check only: 1 stock check (seller given), 0 deposit check
//  proto_err    out  1   one-cycle pulse on any input-protocol violation
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, user register 0, user_set flag 0.
//  FSM states: IDLE, ITEM, NUM, SELLER, AMNT, CHK_WAIT, OUT.
//  IDLE: id_valid -> latch D[7:0] into cmd_user, set user_set and new_user.
//    act_valid -> latch D[3:0]. Buy/Return go to ITEM, Deposit to AMNT,
//    Check to CHK_WAIT with the counter cleared.
//  ITEM --item_valid--> NUM --num_valid--> SELLER --id_valid--> OUT.
//  AMNT --amnt_valid--> OUT.
//  CHK_WAIT: id_valid before the count expires -> latch seller, chk_stk=1, go to OUT.
//    Otherwise the counter increments once per cycle. When the counter reaches
//    CHK_WAIT-1 with no id_valid -> chk_stk=0, go to OUT.
//  OUT: cmd_valid=1, all cmd_* held stable. On cmd_ready: cmd_valid=0 next
//    cycle, new_user cleared, per-command fields cleared, return to IDLE.
//  Latency: cmd_valid rises the cycle after the last field is captured.
//    For a deposit check it rises CHK_WAIT cycles after act_valid.
//  cmd_ready is ignored outside OUT. A ready/valid transfer happens only on a
//    cycle where both are high.
//  Violations: proto_err pulses for 1 cycle, the offending data is dropped,
//    and the state is unchanged. Violations are:
//    - more than one *_valid high in the same cycle;
//    - a valid that is not expected in the current state (includes any valid in OUT);
//    - act_valid while user_set=0;
//    - an act code other than 1, 2, 4 or 8.
//  An action may follow a new id_valid with any gap. A second id_valid in IDLE
//    overwrites the user; last one wins.
//  user_set and cmd_user persist across commands and clear only on reset.
//  Reset asserted mid-command drops the partial command immediately.
//    cmd_valid falls asynchronously.
// TESTING
//  1. Reset release, then act_valid D=1 with no prior id. Expect proto_err=1 for 1 cycle, cmd_valid stays 0.
//  2. id 0x12, act Buy, item 3, num 5, id 0x40. One cycle later expect cmd_valid with
//     act=1, user=0x12, new_user=1, item=3, num=5, seller=0x40.
//  3. Check with id 0x07 two cycles after act. Expect chk_stk=1, seller=0x07.
//     Check with no id. Expect cmd_valid exactly 6 cycles after act_valid, chk_stk=0, seller=0.
//  4. Deposit amnt 0xFFFF with cmd_ready held low for 10 cycles. Expect cmd_valid and
//     amnt=0xFFFF held stable all 10 cycles, then one cycle after ready cmd_valid=0.
//     Next command has new_user=0.
//  5. item_valid and num_valid high in the same cycle in state ITEM. Expect proto_err,
//     state stays ITEM. act_valid D=3. Expect proto_err, state stays IDLE.
//  6. rst pulse while in NUM. Expect all outputs 0. A following act_valid without an id gives proto_err.

Source files
------------

// File: rtl/os_cmd_collector_if.sv
// Command-collector bus: serial valid-qualified fields in on the shared D bus,
// one assembled command out through a valid/ready handshake.
interface os_cmd_collector_if;
  logic        id_valid;
  logic        act_valid;
  logic        item_valid;
  logic        num_valid;
  logic        amnt_valid;
  logic [15:0] D;
  logic        cmd_ready;
  logic        cmd_valid;
  logic [3:0]  cmd_act;
  logic [7:0]  cmd_user;
  logic        cmd_new_user;
  logic [7:0]  cmd_seller;
  logic [1:0]  cmd_item;
  logic [5:0]  cmd_num;
  logic [15:0] cmd_amnt;
  logic        cmd_chk_stk;
  logic        proto_err;

  modport master (
    output id_valid, act_valid, item_valid, num_valid, amnt_valid, D, cmd_ready,
    input  cmd_valid, cmd_act, cmd_user, cmd_new_user, cmd_seller, cmd_item,
           cmd_num, cmd_amnt, cmd_chk_stk, proto_err
  );

  modport slave (
    input  id_valid, act_valid, item_valid, num_valid, amnt_valid, D, cmd_ready,
    output cmd_valid, cmd_act, cmd_user, cmd_new_user, cmd_seller, cmd_item,
           cmd_num, cmd_amnt, cmd_chk_stk, proto_err
  );
endinterface

// File: rtl/os_cmd_collector.sv
// Online-shopping front end: gathers serial fields from the D bus into one
// command and offers it downstream with a valid/ready handshake.
module os_cmd_collector #(
  parameter int unsigned CHK_WAIT = 6
) (
  input  logic                clk,
  input  logic                rst,
  os_cmd_collector_if.slave   bus
);

  localparam int unsigned CNT_W = (CHK_WAIT > 2) ? $clog2(CHK_WAIT) : 1;

  localparam logic [3:0] ACT_BUY = 4'd1;
  localparam logic [3:0] ACT_CHK = 4'd2;
  localparam logic [3:0] ACT_DEP = 4'd4;
  localparam logic [3:0] ACT_RET = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ITEM,
    S_NUM,
    S_SELLER,
    S_AMNT,
    S_CHK_WAIT,
    S_OUT
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       user_q, user_d;
  logic             user_set_q, user_set_d;
  logic             new_user_q, new_user_d;
  logic [3:0]       act_q, act_d;
  logic [7:0]       seller_q, seller_d;
  logic [1:0]       item_q, item_d;
  logic [5:0]       num_q, num_d;
  logic [15:0]      amnt_q, amnt_d;
  logic             chk_stk_q, chk_stk_d;
  logic             valid_q, valid_d;
  logic             proto_err_q, proto_err_d;

  logic [2:0]       n_valid;
  logic             multi_valid;
  logic             any_valid;
  logic             act_code_ok;
  logic             chk_expire;
  logic [3:0]       act_in;

  // Input qualification shared by every state.
  always_comb begin
    n_valid     = 3'(bus.id_valid) + 3'(bus.act_valid) + 3'(bus.item_valid)
                + 3'(bus.num_valid) + 3'(bus.amnt_valid);
    multi_valid = (n_valid > 3'd1);
    any_valid   = (n_valid != 3'd0);
    act_in      = bus.D[3:0];
    act_code_ok = (act_in == ACT_BUY) || (act_in == ACT_CHK) ||
                  (act_in == ACT_DEP) || (act_in == ACT_RET);
    // Counter is about to reach CHK_WAIT-1: leave so cmd_valid lands CHK_WAIT cycles after act.
    chk_expire  = ((32'(cnt_q) + 32'd1) >= (CHK_WAIT - 32'd1));
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    user_d      = user_q;
    user_set_d  = user_set_q;
    new_user_d  = new_user_q;
    act_d       = act_q;
    seller_d    = seller_q;
    item_d      = item_q;
    num_d       = num_q;
    amnt_d      = amnt_q;
    chk_stk_d   = chk_stk_q;
    proto_err_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (multi_valid) begin
          proto_err_d = 1'b1;
        end else if (bus.id_valid) begin
          user_d     = bus.D[7:0];
          user_set_d = 1'b1;
          new_user_d = 1'b1;
        end else if (bus.act_valid) begin
          if (!user_set_q || !act_code_ok) begin
            proto_err_d = 1'b1;
          end else begin
            act_d = act_in;
            unique case (act_in)
              ACT_DEP: state_d = S_AMNT;
              ACT_CHK: begin
                state_d = S_CHK_WAIT;
                cnt_d   = '0;
              end
              default: state_d = S_ITEM;
            endcase
          end
        end else if (any_valid) begin
          proto_err_d = 1'b1;
        end
      end

      S_ITEM: begin
        if (bus.item_valid && !multi_valid) begin
          item_d  = bus.D[1:0];
          state_d = S_NUM;
        end else if (any_valid) begin
          proto_err_d = 1'b1;
        end
      end

      S_NUM: begin
        if (bus.num_valid && !multi_valid) begin
          num_d   = bus.D[5:0];
          state_d = S_SELLER;
        end else if (any_valid) begin
          proto_err_d = 1'b1;
        end
      end

      S_SELLER: begin
        if (bus.id_valid && !multi_valid) begin
          seller_d = bus.D[7:0];
          state_d  = S_OUT;
        end else if (any_valid) begin
          proto_err_d = 1'b1;
        end
      end

      S_AMNT: begin
        if (bus.amnt_valid && !multi_valid) begin
          amnt_d  = bus.D;
          state_d = S_OUT;
        end else if (any_valid) begin
          proto_err_d = 1'b1;
        end
      end

      // A dropped stray valid does not stop the check timeout from running.
      S_CHK_WAIT: begin
        if (bus.id_valid && !multi_valid) begin
          seller_d  = bus.D[7:0];
          chk_stk_d = 1'b1;
          state_d   = S_OUT;
        end else begin
          proto_err_d = any_valid;
          if (chk_expire) begin
            chk_stk_d = 1'b0;
            state_d   = S_OUT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      S_OUT: begin
        proto_err_d = any_valid;
        if (bus.cmd_ready) begin
          new_user_d = 1'b0;
          act_d      = '0;
          seller_d   = '0;
          item_d     = '0;
          num_d      = '0;
          amnt_d     = '0;
          chk_stk_d  = 1'b0;
          cnt_d      = '0;
          state_d    = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    valid_d = (state_d == S_OUT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      user_q      <= '0;
      user_set_q  <= 1'b0;
      new_user_q  <= 1'b0;
      act_q       <= '0;
      seller_q    <= '0;
      item_q      <= '0;
      num_q       <= '0;
      amnt_q      <= '0;
      chk_stk_q   <= 1'b0;
      valid_q     <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      user_q      <= user_d;
      user_set_q  <= user_set_d;
      new_user_q  <= new_user_d;
      act_q       <= act_d;
      seller_q    <= seller_d;
      item_q      <= item_d;
      num_q       <= num_d;
      amnt_q      <= amnt_d;
      chk_stk_q   <= chk_stk_d;
      valid_q     <= valid_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign bus.cmd_valid    = valid_q;
  assign bus.cmd_act      = act_q;
  assign bus.cmd_user     = user_q;
  assign bus.cmd_new_user = new_user_q;
  assign bus.cmd_seller   = seller_q;
  assign bus.cmd_item     = item_q;
  assign bus.cmd_num      = num_q;
  assign bus.cmd_amnt     = amnt_q;
  assign bus.cmd_chk_stk  = chk_stk_q;
  assign bus.proto_err    = proto_err_q;

endmodule

// File: tb/tb_os_cmd_collector.sv
// Directed bench for os_cmd_collector: hand-computed expectations checked with
// immediate assertions, one linear stimulus sequence.
module tb_os_cmd_collector;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  os_cmd_collector_if bus ();

  os_cmd_collector #(.CHK_WAIT(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // v = {id, act, item, num, amnt}; holds the field for one cycle
  task automatic send(input logic [4:0] v, input logic [15:0] d);
    bus.id_valid   = v[4];
    bus.act_valid  = v[3];
    bus.item_valid = v[2];
    bus.num_valid  = v[1];
    bus.amnt_valid = v[0];
    bus.D          = d;
    tick();
    bus.id_valid   = 1'b0;
    bus.act_valid  = 1'b0;
    bus.item_valid = 1'b0;
    bus.num_valid  = 1'b0;
    bus.amnt_valid = 1'b0;
    bus.D          = 16'h0;
  endtask

  task automatic accept();
    bus.cmd_ready = 1'b1;
    tick();
    bus.cmd_ready = 1'b0;
  endtask

  localparam logic [4:0] V_ID   = 5'b10000;
  localparam logic [4:0] V_ACT  = 5'b01000;
  localparam logic [4:0] V_ITEM = 5'b00100;
  localparam logic [4:0] V_NUM  = 5'b00010;
  localparam logic [4:0] V_AMNT = 5'b00001;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.id_valid = 1'b0; bus.act_valid = 1'b0; bus.item_valid = 1'b0;
    bus.num_valid = 1'b0; bus.amnt_valid = 1'b0; bus.D = 16'h0; bus.cmd_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", 16'(bus.cmd_valid), 16'h0);
    chk("rst_user",  16'(bus.cmd_user),  16'h0);
    chk("rst_err",   16'(bus.proto_err), 16'h0);
    rst = 1'b0;
    tick();

    // 1: act with no user id
    send(V_ACT, 16'h0001);
    chk("t1_err",   16'(bus.proto_err), 16'h1);
    chk("t1_valid", 16'(bus.cmd_valid), 16'h0);
    tick();
    chk("t1_err_pulse", 16'(bus.proto_err), 16'h0);
    chk("t1_valid2",    16'(bus.cmd_valid), 16'h0);

    // 2: full Buy
    send(V_ID, 16'h0012);
    chk("t2_user", 16'(bus.cmd_user), 16'h12);
    send(V_ACT,  16'h0001);
    send(V_ITEM, 16'h0003);
    send(V_NUM,  16'h0005);
    chk("t2_valid_early", 16'(bus.cmd_valid), 16'h0);
    send(V_ID,   16'h0040);
    chk("t2_valid",  16'(bus.cmd_valid),    16'h1);
    chk("t2_act",    16'(bus.cmd_act),      16'h1);
    chk("t2_user2",  16'(bus.cmd_user),     16'h12);
    chk("t2_new",    16'(bus.cmd_new_user), 16'h1);
    chk("t2_item",   16'(bus.cmd_item),     16'h3);
    chk("t2_num",    16'(bus.cmd_num),      16'h5);
    chk("t2_seller", 16'(bus.cmd_seller),   16'h40);
    chk("t2_amnt",   16'(bus.cmd_amnt),     16'h0);
    accept();
    chk("t2_drop",   16'(bus.cmd_valid),    16'h0);
    chk("t2_newclr", 16'(bus.cmd_new_user), 16'h0);
    chk("t2_actclr", 16'(bus.cmd_act),      16'h0);

    // 3a: stock check, seller two cycles after act
    send(V_ACT, 16'h0002);
    tick();
    send(V_ID, 16'h0007);
    chk("t3a_valid",  16'(bus.cmd_valid),    16'h1);
    chk("t3a_stk",    16'(bus.cmd_chk_stk),  16'h1);
    chk("t3a_seller", 16'(bus.cmd_seller),   16'h07);
    chk("t3a_act",    16'(bus.cmd_act),      16'h2);
    chk("t3a_new",    16'(bus.cmd_new_user), 16'h0);
    accept();

    // 3b: deposit check, cmd_valid exactly 6 cycles after act
    send(V_ACT, 16'h0002);
    for (int i = 1; i <= 5; i++) begin
      chk($sformatf("t3b_wait%0d", i), 16'(bus.cmd_valid), 16'h0);
      tick();
    end
    chk("t3b_valid",  16'(bus.cmd_valid),   16'h1);
    chk("t3b_stk",    16'(bus.cmd_chk_stk), 16'h0);
    chk("t3b_seller", 16'(bus.cmd_seller),  16'h0);
    accept();

    // 4: deposit held while downstream stalls
    send(V_ACT,  16'h0004);
    send(V_AMNT, 16'hFFFF);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t4_hold_v%0d", i), 16'(bus.cmd_valid), 16'h1);
      chk($sformatf("t4_hold_a%0d", i), bus.cmd_amnt,       16'hFFFF);
      tick();
    end
    chk("t4_new", 16'(bus.cmd_new_user), 16'h0);
    accept();
    chk("t4_drop",    16'(bus.cmd_valid), 16'h0);
    chk("t4_amntclr", bus.cmd_amnt,       16'h0);

    // 5: two valids in ITEM, then a bad act code in IDLE
    send(V_ACT, 16'h0008);
    send(V_ITEM | V_NUM, 16'h0003);
    chk("t5_multi_err", 16'(bus.proto_err), 16'h1);
    chk("t5_item_kept", 16'(bus.cmd_item),  16'h0);
    send(V_ITEM, 16'h0002);
    chk("t5_item_ok", 16'(bus.proto_err), 16'h0);
    send(V_NUM, 16'h0001);
    send(V_ID,  16'h0055);
    chk("t5_valid",  16'(bus.cmd_valid),  16'h1);
    chk("t5_act",    16'(bus.cmd_act),    16'h8);
    chk("t5_item",   16'(bus.cmd_item),   16'h2);
    chk("t5_num",    16'(bus.cmd_num),    16'h1);
    chk("t5_seller", 16'(bus.cmd_seller), 16'h55);
    send(V_AMNT, 16'h0099);
    chk("t5_out_err",  16'(bus.proto_err), 16'h1);
    chk("t5_out_amnt", bus.cmd_amnt,       16'h0);
    accept();
    send(V_ACT, 16'h0003);
    chk("t5_badact_err",   16'(bus.proto_err), 16'h1);
    chk("t5_badact_valid", 16'(bus.cmd_valid), 16'h0);
    send(V_ACT,  16'h0004);
    send(V_AMNT, 16'h1234);
    chk("t5_idle_kept", 16'(bus.cmd_valid), 16'h1);
    chk("t5_dep_amnt",  bus.cmd_amnt,       16'h1234);
    accept();

    // Second id overwrites the first
    send(V_ID, 16'h0021);
    send(V_ID, 16'h0022);
    send(V_ACT,  16'h0004);
    send(V_AMNT, 16'h0005);
    chk("ow_user", 16'(bus.cmd_user),     16'h22);
    chk("ow_new",  16'(bus.cmd_new_user), 16'h1);
    accept();

    // 6: reset mid-command in NUM
    send(V_ACT,  16'h0001);
    send(V_ITEM, 16'h0001);
    chk("t6_pre_act", 16'(bus.cmd_act), 16'h1);
    rst = 1'b1;
    #2;
    chk("t6_act",   16'(bus.cmd_act),   16'h0);
    chk("t6_item",  16'(bus.cmd_item),  16'h0);
    chk("t6_user",  16'(bus.cmd_user),  16'h0);
    chk("t6_valid", 16'(bus.cmd_valid), 16'h0);
    tick();
    rst = 1'b0;
    tick();
    send(V_ACT, 16'h0001);
    chk("t6_noid_err", 16'(bus.proto_err), 16'h1);
    chk("t6_noid_val", 16'(bus.cmd_valid), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
